// File: rtl/rptr_handler.sv
// Read-side pointer controller for the async FIFO: binary/Gray read pointers, empty, almost_empty, level, sticky underflow.
// Latency: all status registered, one r_clk edge after r_en / g_wptr_sync; r_addr is a combinational slice of b_rptr.
// Backpressure: reads while empty are refused (pointers hold) and latch underflow until clr_uflow.
module rptr_handler #(
  parameter int PTR_WIDTH = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  input  logic                 r_en,
  input  logic [PTR_WIDTH-1:0] g_wptr_sync,
  input  logic                 clr_uflow,
  output logic [PTR_WIDTH-1:0] b_rptr,
  output logic [PTR_WIDTH-1:0] g_rptr,
  output logic [PTR_WIDTH-2:0] r_addr,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [PTR_WIDTH-1:0] r_level,
  output logic                 underflow
);

  logic [PTR_WIDTH-1:0] b_rptr_q, b_rptr_d;
  logic [PTR_WIDTH-1:0] g_rptr_q, g_rptr_d;
  logic [PTR_WIDTH-1:0] level_q, level_d;
  logic [PTR_WIDTH-1:0] b_wptr_sync;
  logic                 empty_q, empty_d;
  logic                 ae_q, ae_d;
  logic                 uflow_q, uflow_d;
  logic                 rd_ok;

  // Gray-to-binary decode of the synchronised write pointer, MSB downward.
  always_comb begin
    b_wptr_sync = '0;
    b_wptr_sync[PTR_WIDTH-1] = g_wptr_sync[PTR_WIDTH-1];
    for (int i = PTR_WIDTH-2; i >= 0; i--) begin
      b_wptr_sync[i] = b_wptr_sync[i+1] ^ g_wptr_sync[i];
    end
  end

  always_comb begin
    rd_ok    = r_en & ~empty_q;
    b_rptr_d = b_rptr_q + {{(PTR_WIDTH-1){1'b0}}, rd_ok};
    g_rptr_d = b_rptr_d ^ (b_rptr_d >> 1);
    empty_d  = (g_rptr_d == g_wptr_sync);
    level_d  = b_wptr_sync - b_rptr_d;
    ae_d     = (level_d <= PTR_WIDTH'(AE_THRESH));
    uflow_d  = uflow_q;
    if (r_en && empty_q) begin
      uflow_d = 1'b1;
    end else if (clr_uflow) begin
      uflow_d = 1'b0;
    end
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      b_rptr_q <= '0;
      g_rptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      ae_q     <= 1'b1;
      uflow_q  <= 1'b0;
    end else begin
      b_rptr_q <= b_rptr_d;
      g_rptr_q <= g_rptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      ae_q     <= ae_d;
      uflow_q  <= uflow_d;
    end
  end

  assign b_rptr       = b_rptr_q;
  assign g_rptr       = g_rptr_q;
  assign r_addr       = b_rptr_q[PTR_WIDTH-2:0];
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign r_level      = level_q;
  assign underflow    = uflow_q;

endmodule

// File: tb/tb_rptr_handler.sv
// Scoreboarded bench for rptr_handler: directed vectors push expected post-edge state, a monitor pops and compares.
module tb_rptr_handler;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
    logic       e;
    logic       ae;
    logic [3:0] lv;
    logic       uf;
  } exp_t;

  logic       r_clk;
  logic       r_rst_n;
  logic       r_en;
  logic [3:0] g_wptr_sync;
  logic       clr_uflow;
  logic [3:0] b_rptr;
  logic [3:0] g_rptr;
  logic [2:0] r_addr;
  logic       empty;
  logic       almost_empty;
  logic [3:0] r_level;
  logic       underflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  rptr_handler #(.PTR_WIDTH(4), .AE_THRESH(2)) dut (
    .r_clk        (r_clk),
    .r_rst_n      (r_rst_n),
    .r_en         (r_en),
    .g_wptr_sync  (g_wptr_sync),
    .clr_uflow    (clr_uflow),
    .b_rptr       (b_rptr),
    .g_rptr       (g_rptr),
    .r_addr       (r_addr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .r_level      (r_level),
    .underflow    (underflow)
  );

  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input exp_t exp);
    n_checks++;
    if (b_rptr !== exp.b || g_rptr !== exp.g || r_addr !== exp.b[2:0] || empty !== exp.e ||
        almost_empty !== exp.ae || r_level !== exp.lv || underflow !== exp.uf) begin
      n_fail++;
      $display("FAIL %s: got b=%0d g=%b addr=%0d e=%b ae=%b lv=%0d uf=%b, want b=%0d g=%b addr=%0d e=%b ae=%b lv=%0d uf=%b",
               name, b_rptr, g_rptr, r_addr, empty, almost_empty, r_level, underflow,
               exp.b, exp.g, exp.b[2:0], exp.e, exp.ae, exp.lv, exp.uf);
    end
  endtask

  // Monitor: every edge, compare against the oldest outstanding expectation.
  initial begin
    exp_t exp;
    forever begin
      @(posedge r_clk);
      #1;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("step", exp);
      end
    end
  end

  task automatic step(input logic en, input logic [3:0] gw, input logic clr,
                      input logic [3:0] eb, input logic [3:0] eg, input logic ee,
                      input logic eae, input logic [3:0] elv, input logic euf);
    @(negedge r_clk);
    r_en        = en;
    g_wptr_sync = gw;
    clr_uflow   = clr;
    sb.push_back('{b: eb, g: eg, e: ee, ae: eae, lv: elv, uf: euf});
  endtask

  initial begin
    r_rst_n     = 1'b0;
    r_en        = 1'b0;
    g_wptr_sync = 4'b0000;
    clr_uflow   = 1'b0;
    #12;
    check("reset", '{b: 4'd0, g: 4'b0000, e: 1'b1, ae: 1'b1, lv: 4'd0, uf: 1'b0});
    @(negedge r_clk);
    r_rst_n = 1'b1;

    // fill three, drain three
    //   en  gw       clr   b     g        e     ae    lv    uf
    step(0, 4'b0000, 0, 4'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);
    step(0, 4'b0010, 0, 4'd0, 4'b0000, 1'b0, 1'b0, 4'd3, 1'b0);
    step(1, 4'b0010, 0, 4'd1, 4'b0001, 1'b0, 1'b1, 4'd2, 1'b0);
    step(1, 4'b0010, 0, 4'd2, 4'b0011, 1'b0, 1'b1, 4'd1, 1'b0);
    step(1, 4'b0010, 0, 4'd3, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b0);
    // underflow: back-to-back read rejected, set beats clear, clear alone, set again
    step(1, 4'b0010, 0, 4'd3, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b1);
    step(1, 4'b0010, 1, 4'd3, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b1);
    step(0, 4'b0010, 1, 4'd3, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b0);
    step(1, 4'b0010, 0, 4'd3, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b1);

    // asynchronous reset in the middle of a cycle
    @(posedge r_clk);
    #3;
    r_rst_n     = 1'b0;
    r_en        = 1'b0;
    g_wptr_sync = 4'b0000;
    clr_uflow   = 1'b0;
    #1;
    check("async_reset", '{b: 4'd0, g: 4'b0000, e: 1'b1, ae: 1'b1, lv: 4'd0, uf: 1'b0});
    @(negedge r_clk);
    r_rst_n = 1'b1;

    // full level: 8 written, nothing read
    step(0, 4'b1100, 0, 4'd0, 4'b0000, 1'b0, 1'b0, 4'd8, 1'b0);
    // read and write together for 16 cycles: pointer wraps 15 -> 0, level holds at 8
    for (int k = 1; k <= 16; k++) begin
      step(1, gray(4'(8 + k)), 0, 4'(k), gray(4'(k)), 1'b0, 1'b0, 4'd8, 1'b0);
    end
    // drain with the write pointer frozen at 8 (Gray 1100)
    for (int k = 1; k <= 8; k++) begin
      step(1, 4'b1100, 0, 4'(k), gray(4'(k)), (k == 8), ((8 - k) <= 2), 4'(8 - k), 1'b0);
    end
    // two more written (level 2), then simultaneous read+write keeps level 2
    step(0, 4'b1111, 0, 4'd8,  4'b1100, 1'b0, 1'b1, 4'd2, 1'b0);
    step(1, 4'b1110, 0, 4'd9,  4'b1101, 1'b0, 1'b1, 4'd2, 1'b0);
    step(1, 4'b1110, 0, 4'd10, 4'b1111, 1'b0, 1'b1, 4'd1, 1'b0);
    step(1, 4'b1110, 0, 4'd11, 4'b1110, 1'b1, 1'b1, 4'd0, 1'b0);
    step(0, 4'b1110, 0, 4'd11, 4'b1110, 1'b1, 1'b1, 4'd0, 1'b0);

    repeat (3) @(negedge r_clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rptr_handler.md
# rptr_handler

Read-side pointer controller for the asynchronous FIFO, the read-domain counterpart of the write pointer handler. It keeps the binary and Gray read pointers and drives the memory read address. It derives `empty`, `almost_empty` and a fill-level estimate from the write pointer after it has been synchronised into the read domain. It also flags reads attempted while the FIFO is empty.

## Interface
Parameters:
- `PTR_WIDTH`, 4, pointer width; FIFO depth = 2^(PTR_WIDTH-1) (8 by default); MSB is the wrap bit.
- `AE_THRESH`, 2, `almost_empty` asserts when the fill level is ≤ this value.

Ports:
- `r_clk` input 1, read-domain clock; all logic is on its rising edge.
- `r_rst_n` input 1, asynchronous active-low reset.
- `r_en` input 1, read request.
- `g_wptr_sync` input PTR_WIDTH, write Gray pointer, already two-flop synchronised into `r_clk`.
- `clr_uflow` input 1, clears the sticky underflow flag.
- `b_rptr` output PTR_WIDTH reg, binary read pointer.
- `g_rptr` output PTR_WIDTH reg, Gray read pointer, sent to the write domain.
- `r_addr` output PTR_WIDTH-1, memory read address, equal to `b_rptr[PTR_WIDTH-2:0]`.
- `empty` output 1 reg, FIFO empty.
- `almost_empty` output 1 reg, fill level ≤ `AE_THRESH`.
- `r_level` output PTR_WIDTH reg, entries available, 0..2^(PTR_WIDTH-1).
- `underflow` output 1 reg, sticky; a read was attempted while empty.

## Operation
- Read accept: `rd_ok = r_en & ~empty`.
- Pointer advance: `b_rptr_next = b_rptr + rd_ok`, modulo 2^PTR_WIDTH.
- Gray code: `g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1)`.
- Empty: `empty_next = (g_rptr_next == g_wptr_sync)`. This is a full PTR_WIDTH compare, including the wrap bit.
- Write pointer decode: Gray-to-binary of `g_wptr_sync`.
  - `b_wptr_sync[MSB] = g[MSB]`.
  - `b_wptr_sync[i] = b_wptr_sync[i+1] ^ g[i]`.
- Level: `level_next = (b_wptr_sync - b_rptr_next)` modulo 2^PTR_WIDTH.
  - The range is 0..2^(PTR_WIDTH-1); the value 2^(PTR_WIDTH-1) means full.
- Almost empty: `almost_empty_next = (level_next <= AE_THRESH)`.
- Underflow:
  - Set when `r_en & empty`.
  - Otherwise cleared when `clr_uflow`.
  - If set and clear occur in the same cycle, set wins.
- Registered outputs: `b_rptr`, `g_rptr`, `empty`, `almost_empty`, `r_level` and `underflow` are registered. `r_addr` is a combinational slice of `b_rptr`.
- A rejected read (`r_en` while `empty`) leaves the pointers unchanged.
- The level is pessimistic, because synchronisation of `g_wptr_sync` lags the real write pointer. The block never reports more entries than exist.

## Timing
- Reset (`r_rst_n` low, asynchronous, takes effect immediately, including mid-operation):
  - `b_rptr` = 0, `g_rptr` = 0, `r_addr` = 0.
  - `empty` = 1, `almost_empty` = 1, `r_level` = 0, `underflow` = 0.
- Leaving reset: the first rising edge after `r_rst_n` rises is the first functional edge.
- Read accept:
  - A read is accepted on edge N when `r_en=1` and `empty=0` in the cycle before N.
  - `b_rptr`, `g_rptr` and `r_addr` take their new values after edge N.
  - The memory word at the old `r_addr` is the word being consumed.
- Last entry: when the read consumes the last entry, `empty` rises on the same edge N. A back-to-back `r_en` in the next cycle is rejected.
- Empty release: when `g_wptr_sync` changes, `empty`, `r_level` and `almost_empty` update on the next edge, one cycle of latency.
- Simultaneous read and write: a read accept and a `g_wptr_sync` advance in the same cycle both contribute, so the level is unchanged if each moves by 1.
- Wrap-around:
  - `b_rptr` goes 2^PTR_WIDTH-1 → 0.
  - `g_rptr` goes 100..0 → 000..0.
  - The empty compare remains correct across the wrap.
- Underflow visibility: `underflow` rises one edge after the offending cycle and holds until cleared.

## Test plan
- Reset: assert `r_rst_n`=0 asynchronously mid-cycle → all outputs take reset values immediately; `empty`=1, `almost_empty`=1, `r_level`=0.
- Fill and drain:
  - Drive `g_wptr_sync`=4'b0010 (3 written) → next edge `empty`=0, `r_level`=3, `almost_empty`=0.
  - Three consecutive reads → `r_level` 2, 1, 0; `almost_empty` returns to 1 at level 2.
  - `empty`=1 on the third read edge; `b_rptr`=3, `g_rptr`=4'b0010.
- Underflow:
  - `r_en`=1 while `empty` → pointers unchanged, `underflow`=1 next edge.
  - Assert `clr_uflow` and `r_en` together while empty → `underflow` stays 1.
  - `clr_uflow` alone → `underflow`=0.
- Full level: `g_wptr_sync`=4'b1100 (8 written) with `b_rptr`=0 → `r_level`=8, `empty`=0.
- Wrap: step `g_wptr_sync` and `r_en` through 16 reads → `b_rptr` goes 15→0, `g_rptr` goes 4'b1000→4'b0000; `empty` correct at each step.
- Simultaneous read/write: at level 2, one accepted read plus `g_wptr_sync` advancing by one → `r_level` stays 2 and `empty` stays 0.
